// File: rtl/uart_cmd_arb.sv
// uart_cmd_arb: round-robin arbiter that shares one UART command port between
// N_REQ requesters, sequences a single outstanding command through the UART
// valid/ready handshake and returns a one-cycle response (with timeout guard)
// to the requester that owns the transaction.
module uart_cmd_arb #(
    parameter int N_REQ      = 4,
    parameter int CMD_WIDTH  = 16,
    parameter int READ_WIDTH = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ*CMD_WIDTH-1:0] req_cmd,
    output logic [N_REQ-1:0]           req_rdy,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic                       rsp_err,
    output logic [READ_WIDTH-1:0]      rsp_data,
    output logic [CMD_WIDTH-1:0]       uart_cmd,
    output logic                       uart_cmd_vld,
    input  logic                       uart_cmd_rdy,
    input  logic                       uart_read_rdy,
    input  logic [READ_WIDTH-1:0]      uart_read_data
);

    localparam int               PTR_W      = $clog2(N_REQ);
    localparam logic [15:0]      TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE        = N_REQ'(1);
    localparam logic [PTR_W-1:0] LAST_REQ   = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_t;

    state_t                  state, state_nxt;
    logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]        owner, owner_nxt;
    logic                    is_wr, is_wr_nxt;
    logic                    seen_busy, seen_busy_nxt;
    logic [15:0]             timer, timer_nxt;

    logic [N_REQ-1:0]        req_rdy_nxt;
    logic [N_REQ-1:0]        rsp_vld_nxt;
    logic                    rsp_err_nxt;
    logic [READ_WIDTH-1:0]   rsp_data_nxt;
    logic [CMD_WIDTH-1:0]    uart_cmd_nxt;
    logic                    uart_cmd_vld_nxt;

    logic [CMD_WIDTH-1:0]    cmd_arr [N_REQ];
    logic                    found;
    logic [PTR_W-1:0]        idx;
    logic [PTR_W-1:0]        win;
    logic [CMD_WIDTH-1:0]    win_cmd;
    logic                    wr_done;
    logic                    rd_done;

    // Unpack the flat command bus into one entry per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cmd_arr[i] = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
        end
    end

    // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        win     = '0;
        win_cmd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
            if (!found && req_vld[idx]) begin
                found   = 1'b1;
                win     = idx;
                win_cmd = cmd_arr[idx];
            end
        end
    end

    // Next-state logic and next values for every registered output.
    always_comb begin
        state_nxt        = state;
        rr_ptr_nxt       = rr_ptr;
        owner_nxt        = owner;
        is_wr_nxt        = is_wr;
        seen_busy_nxt    = seen_busy;
        timer_nxt        = timer;
        req_rdy_nxt      = '0;
        rsp_vld_nxt      = '0;
        rsp_err_nxt      = 1'b0;
        rsp_data_nxt     = '0;
        uart_cmd_nxt     = uart_cmd;
        uart_cmd_vld_nxt = 1'b0;
        wr_done          = 1'b0;
        rd_done          = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    req_rdy_nxt      = ONE << win;
                    uart_cmd_nxt     = win_cmd;
                    owner_nxt        = win;
                    is_wr_nxt        = win_cmd[CMD_WIDTH-1];
                    timer_nxt        = '0;
                    uart_cmd_vld_nxt = 1'b1;
                    state_nxt        = ISSUE;
                end
            end

            ISSUE: begin
                timer_nxt = timer + 16'd1;
                if (timer == TIMER_LAST) begin
                    rsp_vld_nxt = ONE << owner;
                    rsp_err_nxt = 1'b1;
                    state_nxt   = RESP;
                end else if (uart_cmd_vld && uart_cmd_rdy) begin
                    seen_busy_nxt = 1'b0;
                    state_nxt     = BUSY;
                end else begin
                    uart_cmd_vld_nxt = 1'b1;
                end
            end

            BUSY: begin
                timer_nxt = timer + 16'd1;
                if (!uart_cmd_rdy) begin
                    seen_busy_nxt = 1'b1;
                end
                wr_done = is_wr && seen_busy && uart_cmd_rdy;
                rd_done = !is_wr && uart_read_rdy;
                if (wr_done || rd_done) begin
                    rsp_vld_nxt  = ONE << owner;
                    rsp_data_nxt = rd_done ? uart_read_data : '0;
                    state_nxt    = RESP;
                end else if (timer == TIMER_LAST) begin
                    rsp_vld_nxt = ONE << owner;
                    rsp_err_nxt = 1'b1;
                    state_nxt   = RESP;
                end
            end

            RESP: begin
                rr_ptr_nxt = (owner == LAST_REQ) ? '0 : owner + PTR_W'(1);
                state_nxt  = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, bookkeeping and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            is_wr        <= 1'b0;
            seen_busy    <= 1'b0;
            timer        <= '0;
            req_rdy      <= '0;
            rsp_vld      <= '0;
            rsp_err      <= 1'b0;
            rsp_data     <= '0;
            uart_cmd     <= '0;
            uart_cmd_vld <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            owner        <= owner_nxt;
            is_wr        <= is_wr_nxt;
            seen_busy    <= seen_busy_nxt;
            timer        <= timer_nxt;
            req_rdy      <= req_rdy_nxt;
            rsp_vld      <= rsp_vld_nxt;
            rsp_err      <= rsp_err_nxt;
            rsp_data     <= rsp_data_nxt;
            uart_cmd     <= uart_cmd_nxt;
            uart_cmd_vld <= uart_cmd_vld_nxt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_arb.sv
// tb_uart_cmd_arb: directed bench for uart_cmd_arb with N_REQ=4 and
// TIMEOUT=100; the bench plays the UART core by hand, step by step.
module tb_uart_cmd_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_vld;
    logic [63:0] req_cmd;
    logic [3:0]  req_rdy;
    logic [3:0]  rsp_vld;
    logic        rsp_err;
    logic [7:0]  rsp_data;
    logic [15:0] uart_cmd;
    logic        uart_cmd_vld;
    logic        uart_cmd_rdy;
    logic        uart_read_rdy;
    logic [7:0]  uart_read_data;

    int checks = 0;
    int errors = 0;

    uart_cmd_arb #(
        .N_REQ      (4),
        .CMD_WIDTH  (16),
        .READ_WIDTH (8),
        .TIMEOUT    (100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_vld        (req_vld),
        .req_cmd        (req_cmd),
        .req_rdy        (req_rdy),
        .rsp_vld        (rsp_vld),
        .rsp_err        (rsp_err),
        .rsp_data       (rsp_data),
        .uart_cmd       (uart_cmd),
        .uart_cmd_vld   (uart_cmd_vld),
        .uart_cmd_rdy   (uart_cmd_rdy),
        .uart_read_rdy  (uart_read_rdy),
        .uart_read_data (uart_read_data)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] vld, input logic cmd_rdy,
                                 input logic rd_rdy, input logic [7:0] rd_data);
        req_vld        = vld;
        uart_cmd_rdy   = cmd_rdy;
        uart_read_rdy  = rd_rdy;
        uart_read_data = rd_data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed test sequence.
    initial begin
        int e;

        // Reset held for three cycles with everyone requesting.
        rst_n   = 1'b0;
        req_cmd = {16'h8003, 16'h8002, 16'h8001, 16'h8000};
        applyStimulus(4'b1111, 1'b1, 1'b0, 8'h00);
        tick(); tick(); tick();
        checkOutput("rst_req_rdy", 32'(req_rdy), 32'h0);
        checkOutput("rst_rsp_vld", 32'(rsp_vld), 32'h0);
        checkOutput("rst_cmd_vld", 32'(uart_cmd_vld), 32'h0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);

        // Round robin over all four requesters, wrapping back to 0.
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            e = k % 4;
            checkOutput("rr_grant", 32'(req_rdy), 32'(4'b0001 << e));
            checkOutput("rr_cmd", 32'(uart_cmd), 32'h8000 + 32'(e));
            checkOutput("rr_cmd_vld", 32'(uart_cmd_vld), 32'h1);
            tick();
            checkOutput("rr_rdy_pulse", 32'(req_rdy), 32'h0);
            checkOutput("rr_vld_drop", 32'(uart_cmd_vld), 32'h0);
            uart_cmd_rdy = 1'b0;
            tick(); tick();
            checkOutput("rr_busy_norsp", 32'(rsp_vld), 32'h0);
            uart_cmd_rdy = 1'b1;
            tick();
            checkOutput("rr_rsp_vld", 32'(rsp_vld), 32'(4'b0001 << e));
            checkOutput("rr_rsp_err", 32'(rsp_err), 32'h0);
            checkOutput("rr_rsp_data", 32'(rsp_data), 32'h0);
            if (k == 4) begin
                req_vld = 4'b0000;
            end
            tick();
            checkOutput("rr_rsp_pulse", 32'(rsp_vld), 32'h0);
            tick();
        end
        checkOutput("idle_no_grant", 32'(req_rdy), 32'h0);
        checkOutput("idle_no_cmd", 32'(uart_cmd_vld), 32'h0);

        // Write from requester 2 with a slow accept and a long busy period.
        req_cmd = {16'h0000, 16'h8A55, 16'h0000, 16'h0000};
        applyStimulus(4'b0100, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("wr_grant", 32'(req_rdy), 32'h4);
        req_vld = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            checkOutput("wr_hold_vld", 32'(uart_cmd_vld), 32'h1);
            checkOutput("wr_hold_cmd", 32'(uart_cmd), 32'h8A55);
            tick();
        end
        checkOutput("wr_hold_vld", 32'(uart_cmd_vld), 32'h1);
        uart_cmd_rdy = 1'b1;
        tick();
        checkOutput("wr_accepted", 32'(uart_cmd_vld), 32'h0);
        uart_cmd_rdy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            checkOutput("wr_busy_norsp", 32'(rsp_vld), 32'h0);
        end
        uart_cmd_rdy = 1'b1;
        tick();
        checkOutput("wr_rsp_vld", 32'(rsp_vld), 32'h4);
        checkOutput("wr_rsp_err", 32'(rsp_err), 32'h0);
        checkOutput("wr_rsp_data", 32'(rsp_data), 32'h0);
        tick();
        checkOutput("wr_rsp_pulse", 32'(rsp_vld), 32'h0);

        // Spurious read strobe while idle must not produce a response.
        applyStimulus(4'b0000, 1'b1, 1'b1, 8'h77);
        tick();
        checkOutput("idle_rd_ignored", 32'(rsp_vld), 32'h0);
        tick();
        checkOutput("idle_rd_ignored2", 32'(rsp_vld), 32'h0);

        // Read from requester 1 returning 8'hC3.
        req_cmd = {16'h0000, 16'h0000, 16'h0012, 16'h0000};
        applyStimulus(4'b0010, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("rd_grant", 32'(req_rdy), 32'h2);
        checkOutput("rd_cmd", 32'(uart_cmd), 32'h0012);
        req_vld = 4'b0000;
        tick();
        uart_cmd_rdy = 1'b0;
        tick(); tick();
        checkOutput("rd_busy_norsp", 32'(rsp_vld), 32'h0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 8'hC3);
        tick();
        checkOutput("rd_rsp_vld", 32'(rsp_vld), 32'h2);
        checkOutput("rd_rsp_data", 32'(rsp_data), 32'hC3);
        checkOutput("rd_rsp_err", 32'(rsp_err), 32'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("rd_rsp_pulse", 32'(rsp_vld), 32'h0);
        checkOutput("rd_data_clear", 32'(rsp_data), 32'h0);

        // Timeout: requester 2 write accepted but the UART never goes busy.
        req_cmd = {16'h0000, 16'h8123, 16'h0000, 16'h0000};
        applyStimulus(4'b0100, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("to_grant", 32'(req_rdy), 32'h4);
        req_vld = 4'b0000;
        for (int n = 1; n < 100; n++) begin
            tick();
            uart_read_rdy  = (n == 50);
            uart_read_data = 8'h5A;
            if (rsp_vld != 4'b0000) begin
                checkOutput("to_early_rsp", 32'(rsp_vld), 32'h0);
            end
        end
        checkOutput("to_wait_norsp", 32'(rsp_vld), 32'h0);
        tick();
        checkOutput("to_rsp_vld", 32'(rsp_vld), 32'h4);
        checkOutput("to_rsp_err", 32'(rsp_err), 32'h1);
        checkOutput("to_rsp_data", 32'(rsp_data), 32'h0);
        tick();
        checkOutput("to_rsp_pulse", 32'(rsp_vld), 32'h0);
        checkOutput("to_err_clear", 32'(rsp_err), 32'h0);

        // Next request after the timeout: requester 1, reset mid-BUSY.
        req_cmd = {16'h0000, 16'h0000, 16'h8077, 16'h0000};
        applyStimulus(4'b0010, 1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("post_to_grant", 32'(req_rdy), 32'h2);
        req_vld = 4'b0000;
        tick();
        uart_cmd_rdy = 1'b0;
        tick(); tick();
        rst_n        = 1'b0;
        uart_cmd_rdy = 1'b1;
        tick();
        checkOutput("mid_rst_rsp_vld", 32'(rsp_vld), 32'h0);
        checkOutput("mid_rst_cmd_vld", 32'(uart_cmd_vld), 32'h0);
        checkOutput("mid_rst_req_rdy", 32'(req_rdy), 32'h0);
        tick();
        checkOutput("mid_rst_rsp_vld2", 32'(rsp_vld), 32'h0);

        // After reset the pointer is back at 0 and a write completes normally.
        req_cmd = {16'h8003, 16'h8002, 16'h8001, 16'h8000};
        applyStimulus(4'b1111, 1'b1, 1'b0, 8'h00);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_grant", 32'(req_rdy), 32'h1);
        checkOutput("post_rst_cmd", 32'(uart_cmd), 32'h8000);
        req_vld = 4'b0000;
        tick();
        uart_cmd_rdy = 1'b0;
        tick();
        uart_cmd_rdy = 1'b1;
        tick();
        checkOutput("post_rst_rsp_vld", 32'(rsp_vld), 32'h1);
        checkOutput("post_rst_rsp_err", 32'(rsp_err), 32'h0);
        tick();
        tick();
        checkOutput("final_idle", 32'(req_rdy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
